// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and window address helper for the CNN pooling datapath.
package cnn_pkg;

  localparam int W      = 28;
  localparam int DATA_W = 32;
  localparam int POOL_W = W / 2;
  localparam int POOL_N = POOL_W * POOL_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    EMIT,
    FIN
  } state_e;

  // sub[1] selects the lower row of the 2x2 window and sub[0] selects the right column.
  function automatic logic [9:0] win_addr(input logic [7:0] pr, input logic [7:0] pc,
                                          input logic [1:0] sub, input int side);
    int a;
    a = (2 * int'(pr) + int'(sub[1])) * side + 2 * int'(pc) + int'(sub[0]);
    return a[9:0];
  endfunction

endpackage

// File: rtl/pool_max_acc.sv
// Signed compare-and-hold register. It loads din when din is greater than the held value.
// Clear takes priority over load and returns the held value to 0, so ReLU falls out of the max.
module pool_max_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] max
);

  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] max_d;

  always_comb begin
    max_d = max_q;
    if (clear) begin
      max_d = '0;
    end else if (load && ($signed(din) > $signed(max_q))) begin
      max_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max = max_q;

endmodule

// File: rtl/relu_maxpool_unit.sv
// Applies 2x2 max-pool with ReLU to a WxW map read from a register file. The first read comes 1 cycle after start and the result 6 cycles after start.
// A stalled result holds steady with no reads issued. The next window's reads start 1 cycle after each handshake.
module relu_maxpool_unit #(
  parameter int W      = cnn_pkg::W,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [9:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_index,
  output logic              busy,
  output logic              done
);

  import cnn_pkg::*;

  localparam logic [7:0] PC_LAST  = 8'(W / 2 - 1);
  localparam logic [7:0] IDX_LAST = 8'((W / 2) * (W / 2) - 1);

  state_e     state_q, state_d;
  logic [1:0] sub_q, sub_d;
  logic [7:0] pr_q, pr_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] idx_q, idx_d;
  logic [9:0] rd_addr_q, rd_addr_d;
  logic       rd_vld_q, rd_vld_d;
  logic       acc_clear;

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    acc_clear = 1'b0;
    rd_vld_d  = (state_q == FETCH);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          sub_d     = 2'd0;
          pr_d      = 8'd0;
          pc_d      = 8'd0;
          idx_d     = 8'd0;
          acc_clear = 1'b1;
        end
      end
      FETCH: begin
        sub_d = sub_q + 2'd1;
        if (sub_q == 2'd3) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = FIN;
          end else begin
            state_d   = FETCH;
            sub_d     = 2'd0;
            idx_d     = idx_q + 8'd1;
            acc_clear = 1'b1;
            if (pc_q == PC_LAST) begin
              pc_d = 8'd0;
              pr_d = pr_q + 8'd1;
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The address is registered so it lines up with rd_en and holds once fetching stops.
    if (state_d == FETCH) begin
      rd_addr_d = win_addr(pr_d, pc_d, sub_d, W);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sub_q     <= 2'd0;
      pr_q      <= 8'd0;
      pc_q      <= 8'd0;
      idx_q     <= 8'd0;
      rd_addr_q <= 10'd0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // rd_data returns one cycle after each FETCH cycle, so the accumulator loads on the delayed strobe.
  pool_max_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clear(acc_clear),
    .load (rd_vld_q),
    .din  (rd_data),
    .max  (out_data)
  );

  assign rd_en     = (state_q == FETCH);
  assign rd_addr   = rd_addr_q;
  assign out_valid = (state_q == EMIT);
  assign out_index = idx_q;
  assign busy      = (state_q == FETCH) || (state_q == CAPTURE) || (state_q == EMIT);
  assign done      = (state_q == FIN);

endmodule
